pcileech_bar_access_arbiter: RTL and testbench
==============================================

Name: pcileech_bar_access_arbiter

Overview:
Shares the single BAR access port of the BAR controller (address, write data, write/read strobes, read data) between NUM_REQ internal requesters, e.g. the TLP RX engine and a shadow-init/DMA engine. It arbitrates round-robin and issues one single-dword transaction at a time. It handles fixed read latency and returns completions to the granted requester. Sits between the TLP engines and the BAR controller.

Parameters:
NUM_REQ, 2, number of requesters (1..8)
RD_LATENCY, 0, cycles from read-strobe cycle to valid bar_rd_data (0..3)
GRANT_W, $clog2(NUM_REQ) min 1, derived width of grant index

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  request accepted (one-hot or zero)
req_we  in  NUM_REQ  1 = write, 0 = read
req_lock  in  NUM_REQ  hold grant for next transaction (only with lock feature)
req_addr  in  NUM_REQ*32  packed byte addresses, requester i at [32i+31:32i]
req_wdata  in  NUM_REQ*32  packed write data
rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owner
rsp_data  out  32  read data (0 for writes), valid with rsp_valid
bar_addr  out  32  to BAR controller
bar_wr_data  out  32  to BAR controller
bar_wr_en  out  1  write strobe
bar_rd_en  out  1  read strobe
bar_rd_data  in  32  from BAR controller
busy  out  1  FSM not in IDLE
grant_idx  out  GRANT_W  current/last owner

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM IDLE, rr pointer = 0 so requester 0 has top priority, latency counter 0.
- FSM states: IDLE, ISSUE, WAIT_RD, RESP.
- IDLE: if any req_valid, pick the first set bit searching from (last_grant+1) mod NUM_REQ upward with wrap. Assert req_ready[g] combinationally this cycle. Capture addr/wdata/we into registers. Set grant_idx=g. Go to ISSUE. If no req_valid, stay.
- ISSUE: exactly one cycle. Drive bar_addr/bar_wr_data from the registers. Assert bar_wr_en (write) or bar_rd_en (read), never both.
  - Write: go to RESP with rsp_data=0.
  - Read with RD_LATENCY=0: sample bar_rd_data this cycle, go to RESP.
  - Read with RD_LATENCY>0: load counter=RD_LATENCY, go to WAIT_RD.
- WAIT_RD: strobes low, bar_addr held stable. Decrement the counter each cycle. Sample bar_rd_data in the cycle the counter reads 1 (i.e. RD_LATENCY cycles after ISSUE), then go to RESP.
- RESP: rsp_valid[g]=1 for one cycle, rsp_data valid. Update last_grant=g, then IDLE. rsp_data holds its value until the next RESP.
- Throughput: one transaction per 3+RD_LATENCY cycles. A back-to-back request is accepted in the IDLE cycle after RESP.
- req_valid dropped before req_ready: nothing issued, no state change.
- req_valid of non-granted requesters is ignored outside IDLE. Their requests are retained by the requesters, not buffered here.
- NUM_REQ=1: arbitration degenerates to a pass-through and grant_idx=0.
- Reset mid-transaction: the transaction is abandoned and no rsp_valid is generated. A strobe already issued is not retracted.
- bar_addr is not range-checked; routing and out-of-range handling belong to the BAR controller.

Optional Feature:
PCILEECH_BAR_ARB_LOCK_EN
- Defined: if req_lock[g] is high when the owner's request is accepted, the following IDLE selects only g. Other requesters are ignored until g issues a transaction with req_lock low, or g's req_valid is low in IDLE, which releases the lock. This gives atomic read-modify-write sequences. rr pointer unchanged while locked.
- Undefined: req_lock ignored, pure round-robin.

Decomposition:
- Package pcileech_bar_arb_pkg: state enum (IDLE, ISSUE, WAIT_RD, RESP), MAX_REQ=8, MAX_RD_LATENCY=3, and a function for the round-robin next-index search.
- Sub-module pcileech_rr_arbiter: combinational round-robin picker. Inputs: request vector, last_grant, optional lock mask. Outputs: one-hot grant and index. Reusable by other shared-resource blocks.

Test Plan:
- Single write: req_valid[0], we=1, addr=0x0000_0010, wdata=0xA5A5_1234 -> req_ready[0] in cycle 0; bar_wr_en=1 with the same addr/data in cycle 1; rsp_valid[0] in cycle 2 with rsp_data=0.
- Read, RD_LATENCY=2: model returns 0xCAFE_0001 two cycles after bar_rd_en at addr 0x20 -> rsp_valid[1] in cycle 4 with rsp_data=0xCAFE_0001; bar_rd_en high exactly one cycle.
- Contention: both requesters valid continuously for 6 transactions -> grants alternate 0,1,0,1,0,1, starting with 0 after reset; never two strobes in one cycle.
- Wrap: NUM_REQ=4, last_grant=3, req_valid=4'b1010 -> grant 1; then last_grant=1, req_valid=4'b0011 -> grant 0.
- Reset asserted during WAIT_RD -> all outputs 0 asynchronously; no rsp_valid after release; next grant goes to requester 0.
- Lock (macro defined): req0 read with lock=1 while req1 valid -> next grant is 0 again. req0 write with lock=0 -> next grant is 1.

Source files
------------

// File: rtl/pcileech_bar_arb_pkg.sv
// Shared types and helpers for the BAR access arbiter.
// Holds the FSM state enum, size limits and the round-robin search.
package pcileech_bar_arb_pkg;

  localparam int MAX_REQ        = 8;
  localparam int MAX_RD_LATENCY = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RD,
    S_RESP
  } arb_state_e;

  // Search req for the first set bit starting at (last+1) mod n.
  // Result bit 3 flags a hit, bits 2:0 hold the winning index.
  function automatic logic [3:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [2:0]         last,
    input int                 n
  );
    logic [3:0] res;
    int         idx;
    res = 4'd0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = int'(last) + k;
      if (idx >= n) idx = idx - n;
      if (k <= n && !res[3] && req[idx[2:0]])
        res = {1'b1, idx[2:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/pcileech_rr_arbiter.sv
// Combinational round-robin picker for shared resources.
// Ports: i_req/i_mask request and eligibility, i_last previous owner; o_grant one-hot, o_idx, o_valid.
module pcileech_rr_arbiter
  import pcileech_bar_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int GRANT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_mask,
  input  logic [GRANT_W-1:0] i_last,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [GRANT_W-1:0] o_idx,
  output logic               o_valid
);

  logic [MAX_REQ-1:0] w_req;
  logic [2:0]         w_last;
  logic [3:0]         w_pick;
  logic               w_unused;

  assign w_req    = MAX_REQ'(i_req & i_mask);
  assign w_last   = 3'(i_last);
  assign w_pick   = rr_pick(w_req, w_last, NUM_REQ);
  assign w_unused = ^w_pick;

  assign o_valid = w_pick[3];
  assign o_idx   = w_pick[GRANT_W-1:0];
  assign o_grant = o_valid ? (NUM_REQ'(1) << o_idx) : '0;

endmodule

// File: rtl/pcileech_bar_access_arbiter.sv
// Shares one BAR access port between NUM_REQ requesters, one dword at a time.
// Ports: req_* requester side, rsp_* completions, bar_* BAR controller; PCILEECH_BAR_ARB_LOCK_EN enables req_lock.
module pcileech_bar_access_arbiter
  import pcileech_bar_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int RD_LATENCY = 0,
  parameter int GRANT_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ-1:0]    req_lock,
  input  logic [NUM_REQ*32-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [31:0]           rsp_data,
  output logic [31:0]           bar_addr,
  output logic [31:0]           bar_wr_data,
  output logic                  bar_wr_en,
  output logic                  bar_rd_en,
  input  logic [31:0]           bar_rd_data,
  output logic                  busy,
  output logic [GRANT_W-1:0]    grant_idx
);

  arb_state_e r_state, w_next;

  logic [31:0]        r_addr, r_wdata, r_rsp_data;
  logic               r_we, r_locked;
  logic [GRANT_W-1:0] r_grant, r_last;
  logic [1:0]         r_cnt;

  logic [NUM_REQ-1:0] w_arb_grant, w_owner_oh, w_lock_mask;
  logic [GRANT_W-1:0] w_arb_idx;
  logic               w_arb_valid, w_own_valid, w_sel_lock, w_sel_we;
  logic [31:0]        w_sel_addr, w_sel_wdata;

  assign w_owner_oh  = NUM_REQ'(1) << r_grant;
  assign w_own_valid = |(req_valid & w_owner_oh);

`ifdef PCILEECH_BAR_ARB_LOCK_EN
  // A locked owner is the only candidate while it keeps requesting.
  assign w_lock_mask = (r_locked && w_own_valid) ? w_owner_oh : '1;
  assign w_sel_lock  = |(req_lock & w_arb_grant);
`else
  logic w_unused_lock;
  assign w_unused_lock = ^req_lock;
  assign w_lock_mask   = '1;
  assign w_sel_lock    = 1'b0;
`endif

  pcileech_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .GRANT_W (GRANT_W)
  ) u_rr (
    .i_req   (req_valid),
    .i_mask  (w_lock_mask),
    .i_last  (r_last),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_we    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_arb_idx == GRANT_W'(i)) begin
        w_sel_addr  = req_addr[32*i +: 32];
        w_sel_wdata = req_wdata[32*i +: 32];
        w_sel_we    = req_we[i];
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    rsp_valid = '0;
    bar_wr_en = 1'b0;
    bar_rd_en = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_arb_valid) begin
          req_ready = w_arb_grant;
          w_next    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        bar_wr_en = r_we;
        bar_rd_en = !r_we;
        if (r_we || RD_LATENCY == 0) w_next = S_RESP;
        else                         w_next = S_WAIT_RD;
      end
      S_WAIT_RD: begin
        if (r_cnt == 2'd1) w_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid = w_owner_oh;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // r_last resets to the top index so the first search starts at 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_locked   <= 1'b0;
      r_grant    <= '0;
      r_last     <= GRANT_W'(NUM_REQ - 1);
      r_cnt      <= 2'd0;
      r_rsp_data <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (w_arb_valid) begin
            r_addr   <= w_sel_addr;
            r_wdata  <= w_sel_wdata;
            r_we     <= w_sel_we;
            r_grant  <= w_arb_idx;
            r_locked <= w_sel_lock;
          end else begin
            r_locked <= r_locked & w_own_valid;
          end
        end
        S_ISSUE: begin
          if (r_we)                 r_rsp_data <= '0;
          else if (RD_LATENCY == 0) r_rsp_data <= bar_rd_data;
          else                      r_cnt      <= 2'(RD_LATENCY);
        end
        S_WAIT_RD: begin
          r_cnt <= r_cnt - 2'd1;
          if (r_cnt == 2'd1) r_rsp_data <= bar_rd_data;
        end
        S_RESP: begin
          if (!r_locked) r_last <= r_grant;
        end
        default: ;
      endcase
    end
  end

  assign bar_addr    = r_addr;
  assign bar_wr_data = r_wdata;
  assign rsp_data    = r_rsp_data;
  assign busy        = (r_state != S_IDLE);
  assign grant_idx   = r_grant;

endmodule

// File: tb/tb_pcileech_bar_access_arbiter.sv
// Directed bench for pcileech_bar_access_arbiter (NUM_REQ=2, RD_LATENCY=2).
// Also exercises a 4-way pcileech_rr_arbiter for wrap-around picks.
module tb_pcileech_bar_access_arbiter;

  localparam int NREQ = 2;
  localparam int LAT  = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_we = '0;
  logic [NREQ-1:0]   req_lock = '0;
  logic [NREQ*32-1:0] req_addr = '0;
  logic [NREQ*32-1:0] req_wdata = '0;
  logic [NREQ-1:0]   rsp_valid;
  logic [31:0]       rsp_data;
  logic [31:0]       bar_addr, bar_wr_data;
  logic              bar_wr_en, bar_rd_en;
  logic [31:0]       bar_rd_data = 32'hDEAD_BEEF;
  logic              busy;
  logic [0:0]        grant_idx;

  logic [3:0] rr_req = '0;
  logic [3:0] rr_mask = 4'hF;
  logic [1:0] rr_last = '0;
  logic [3:0] rr_grant;
  logic [1:0] rr_idx;
  logic       rr_valid;

  logic [31:0] r_pipe = 32'hDEAD_BEEF;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pcileech_bar_access_arbiter #(
    .NUM_REQ    (NREQ),
    .RD_LATENCY (LAT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_lock    (req_lock),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .bar_addr    (bar_addr),
    .bar_wr_data (bar_wr_data),
    .bar_wr_en   (bar_wr_en),
    .bar_rd_en   (bar_rd_en),
    .bar_rd_data (bar_rd_data),
    .busy        (busy),
    .grant_idx   (grant_idx)
  );

  pcileech_rr_arbiter #(
    .NUM_REQ (4)
  ) u_rr4 (
    .i_req   (rr_req),
    .i_mask  (rr_mask),
    .i_last  (rr_last),
    .o_grant (rr_grant),
    .o_idx   (rr_idx),
    .o_valid (rr_valid)
  );

  // BAR model: read data appears two cycles after the strobe cycle.
  always @(posedge clk) begin
    r_pipe      <= bar_rd_en ? (32'hCAFE_0000 | (bar_addr >> 5))
                             : 32'hDEAD_BEEF;
    bar_rd_data <= r_pipe;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy && c < 20) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("idle", 32'(busy), 32'd0);
  endtask

  task automatic xfer(input int idx, input bit we,
                      input logic [31:0] addr,
                      input logic [31:0] wd,
                      output logic [31:0] rd);
    int c;
    @(negedge clk);
    req_valid[idx] = 1'b1;
    req_we[idx]    = we;
    req_addr[32*idx +: 32]  = addr;
    req_wdata[32*idx +: 32] = wd;
    #1;
    check("xfer_rdy", 32'(req_ready), 32'(1 << idx));
    @(negedge clk);
    req_valid[idx] = 1'b0;
    #1;
    c = 0;
    while (rsp_valid == '0 && c < 20) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("xfer_rsp", 32'(rsp_valid), 32'(1 << idx));
    rd = rsp_data;
    wait_idle();
  endtask

  initial begin
    logic [31:0] rd;
    int          gseq[6];
    int          ng, c, rd_cnt;
    bit          both, seen;

    // reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdy", 32'(req_ready), 32'd0);
    check("rst_strb", 32'({bar_wr_en, bar_rd_en}), 32'd0);
    check("rst_addr", bar_addr, 32'd0);
    check("rst_gnt", 32'(grant_idx), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // single write from requester 0
    @(negedge clk);
    req_valid = 2'b01; req_we = 2'b01;
    req_addr[31:0] = 32'h0000_0010;
    req_wdata[31:0] = 32'hA5A5_1234;
    #1;
    check("wr_rdy", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    check("wr_en", 32'({bar_wr_en, bar_rd_en}), 32'd2);
    check("wr_addr", bar_addr, 32'h0000_0010);
    check("wr_data", bar_wr_data, 32'hA5A5_1234);
    @(negedge clk); #1;
    check("wr_rspv", 32'(rsp_valid), 32'd1);
    check("wr_rspd", rsp_data, 32'd0);
    @(negedge clk); #1;
    check("wr_done", 32'({busy, rsp_valid}), 32'd0);

    // read from requester 1 with latency 2
    @(negedge clk);
    req_valid = 2'b10; req_we = 2'b00;
    req_addr[63:32] = 32'h0000_0020;
    #1;
    check("rd_rdy", 32'(req_ready), 32'd2);
    rd_cnt = 0;
    for (int cy = 1; cy <= 4; cy++) begin
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      if (bar_rd_en) rd_cnt++;
      if (cy == 1) check("rd_gnt", 32'(grant_idx), 32'd1);
      if (cy == 3) check("rd_addr", bar_addr, 32'h0000_0020);
      if (cy < 4) check("rd_nrsp", 32'(rsp_valid), 32'd0);
    end
    check("rd_rspv", 32'(rsp_valid), 32'd2);
    check("rd_rspd", rsp_data, 32'hCAFE_0001);
    check("rd_strb1", 32'(rd_cnt), 32'd1);
    @(negedge clk); #1;
    check("rd_hold", rsp_data, 32'hCAFE_0001);

    // contention: grants must alternate 0,1,0,1,0,1
    @(negedge clk);
    req_we = 2'b11;
    req_addr = {32'h0000_0200, 32'h0000_0100};
    req_valid = 2'b11;
    #1;
    ng = 0; c = 0; both = 1'b0;
    while (ng < 6 && c < 40) begin
      if (bar_wr_en && bar_rd_en) both = 1'b1;
      if (req_ready != '0) begin
        gseq[ng] = (req_ready == 2'b10) ? 1 : 0;
        ng++;
      end
      if (ng < 6) begin
        @(negedge clk); #1;
      end
      c++;
    end
    @(negedge clk);
    req_valid = 2'b00;
    wait_idle();
    check("cont_cnt", 32'(ng), 32'd6);
    check("cont_strb", 32'(both), 32'd0);
    for (int i = 0; i < 6; i++)
      check("cont_gnt", 32'(gseq[i]), 32'(i % 2));

    // rr picker wrap-around with four requesters
    rr_req = 4'b1010; rr_last = 2'd3;
    #1;
    check("wrap_a", 32'({rr_valid, rr_idx}), 32'h5);
    check("wrap_ag", 32'(rr_grant), 32'h2);
    rr_req = 4'b0011; rr_last = 2'd1;
    #1;
    check("wrap_b", 32'({rr_valid, rr_idx}), 32'h4);
    rr_req = 4'b1111; rr_mask = 4'b0100; rr_last = 2'd3;
    #1;
    check("wrap_mask", 32'(rr_idx), 32'd2);
    rr_req = 4'b0000; rr_mask = 4'hF;
    #1;
    check("wrap_none", 32'({rr_valid, rr_grant}), 32'd0);

    // reset during WAIT_RD
    xfer(0, 1'b1, 32'h0000_0030, 32'h1111_2222, rd);
    check("pre_rst_d", rd, 32'd0);
    @(negedge clk);
    req_valid = 2'b10; req_we = 2'b00;
    req_addr[63:32] = 32'h0000_0040;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk); #1;
    check("wrd_busy", 32'(busy), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_addr", bar_addr, 32'd0);
    check("arst_gnt", 32'(grant_idx), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (rsp_valid != '0) seen = 1'b1;
    end
    check("arst_norsp", 32'(seen), 32'd0);
    @(negedge clk);
    req_valid = 2'b11; req_we = 2'b11;
    #1;
    check("arst_gnt0", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    wait_idle();

`ifdef PCILEECH_BAR_ARB_LOCK_EN
    xfer(1, 1'b1, 32'h0000_0050, 32'h0, rd);
    @(negedge clk);
    req_valid = 2'b11; req_we = 2'b00; req_lock = 2'b01;
    #1;
    check("lock_g0", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_we = 2'b01; req_lock = 2'b00;
    #1;
    c = 0;
    while (req_ready == '0 && c < 20) begin
      @(negedge clk); #1; c++;
    end
    check("lock_g1", 32'(req_ready), 32'd1);
    @(negedge clk); #1;
    c = 0;
    while (req_ready == '0 && c < 20) begin
      @(negedge clk); #1; c++;
    end
    check("lock_rel", 32'(req_ready), 32'd2);
    @(negedge clk);
    req_valid = 2'b00;
    wait_idle();
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
